// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, bias and operand layout for the FP align path
// Build option: FP_ALIGN_SUBNORM_EN (subnormal operands kept; otherwise flushed to zero).
package fp_pkg;

  localparam int unsigned FP_EXP_W   = 8;
  localparam int unsigned FP_MAN_W   = 23;
  localparam int unsigned FP_GUARD_W = 3;
  localparam int unsigned FP_EXP_BIAS = (1 << (FP_EXP_W - 1)) - 1;

  // {hidden, man} and {hidden, man, guard/round/sticky}
  localparam int unsigned FP_SIG_W   = FP_MAN_W + 1;
  localparam int unsigned FP_ALIGN_W = FP_SIG_W + FP_GUARD_W;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp_operand_t;

endpackage

// File: rtl/fp_align_shifter.sv
// rtl/fp_align_shifter.sv - combinational right barrel shifter with sticky LSB and saturation
// Ports:
//   data_i  [W-1:0]    value to shift
//   shamt_i [SH_W-1:0] right shift amount
//   data_o  [W-1:0]    shifted value; every bit shifted out is ORed into bit 0
module fp_align_shifter #(
  parameter int unsigned W    = 27,
  parameter int unsigned SH_W = 8
) (
  input  logic [W-1:0]    data_i,
  input  logic [SH_W-1:0] shamt_i,
  output logic [W-1:0]    data_o
);

  logic [W-1:0] shifted;
  logic [W-1:0] lost_mask;
  logic         sticky;

  always_comb begin
    shifted   = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    data_o    = '0;
    if (32'(shamt_i) >= W) begin
      // Everything falls off the end: only the sticky summary survives.
      data_o = {{(W-1){1'b0}}, |data_i};
    end else begin
      shifted   = data_i >> shamt_i;
      lost_mask = ~({W{1'b1}} << shamt_i);
      sticky    = |(data_i & lost_mask);
      data_o    = {shifted[W-1:1], shifted[0] | sticky};
    end
  end

endmodule

// File: rtl/fp_align_pipe.sv
// rtl/fp_align_pipe.sv - two-stage FP operand magnitude compare and significand align pipeline
// Build option: FP_ALIGN_SUBNORM_EN (subnormals get effective exponent 1; otherwise exp=0 is zero).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready, in_a/in_b  operand pair {sign, exp, man} with handshake
//   out_valid/out_ready           result handshake
//   out_swap, out_big_sign, out_eff_sub, out_big_exp, out_exp_diff,
//   out_big_man, out_small_man, out_special   ordered/aligned pair for the adder
module fp_align_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W   = FP_EXP_W,
  parameter int unsigned MAN_W   = FP_MAN_W,
  parameter int unsigned GUARD_W = FP_GUARD_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       in_a,
  input  logic [EXP_W+MAN_W:0]       in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_swap,
  output logic                       out_big_sign,
  output logic                       out_eff_sub,
  output logic [EXP_W-1:0]           out_big_exp,
  output logic [EXP_W-1:0]           out_exp_diff,
  output logic [MAN_W:0]             out_big_man,
  output logic [MAN_W+GUARD_W:0]     out_small_man,
  output logic                       out_special
);

  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned AL_W  = SIG_W + GUARD_W;

  // Stage 1 combinational decode/compare
  logic [EXP_W-1:0] exp_a, exp_b, eexp_a, eexp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             hid_a, hid_b;
  logic             s1_swap_d, s1_big_sign_d, s1_eff_sub_d, s1_special_d;
  logic [EXP_W-1:0] s1_big_exp_d, s1_exp_diff_d;
  logic [SIG_W-1:0] s1_big_man_d, s1_small_sig_d;

  // Stage 1 registers
  logic             s1_valid_q;
  logic             s1_swap_q, s1_big_sign_q, s1_eff_sub_q, s1_special_q;
  logic [EXP_W-1:0] s1_big_exp_q, s1_exp_diff_q;
  logic [SIG_W-1:0] s1_big_man_q, s1_small_sig_q;

  // Stage 2 (output) registers
  logic             out_valid_q;
  logic             out_swap_q, out_big_sign_q, out_eff_sub_q, out_special_q;
  logic [EXP_W-1:0] out_big_exp_q, out_exp_diff_q;
  logic [SIG_W-1:0] out_big_man_q;
  logic [AL_W-1:0]  out_small_man_q, out_small_man_d;

  logic out_adv;

  always_comb begin
    exp_a = in_a[EXP_W+MAN_W-1:MAN_W];
    exp_b = in_b[EXP_W+MAN_W-1:MAN_W];
    hid_a = |exp_a;
    hid_b = |exp_b;
`ifdef FP_ALIGN_SUBNORM_EN
    man_a  = in_a[MAN_W-1:0];
    man_b  = in_b[MAN_W-1:0];
    // A subnormal sits at the same scale as exponent 1; a true zero stays at 0.
    eexp_a = hid_a ? exp_a : EXP_W'(|man_a);
    eexp_b = hid_b ? exp_b : EXP_W'(|man_b);
`else
    man_a  = hid_a ? in_a[MAN_W-1:0] : '0;
    man_b  = hid_b ? in_b[MAN_W-1:0] : '0;
    eexp_a = exp_a;
    eexp_b = exp_b;
`endif
    // Ties keep A as the big operand.
    s1_swap_d     = {exp_a, man_a} < {exp_b, man_b};
    s1_eff_sub_d  = in_a[EXP_W+MAN_W] ^ in_b[EXP_W+MAN_W];
    s1_special_d  = (&exp_a) | (&exp_b);
    s1_big_sign_d = s1_swap_d ? in_b[EXP_W+MAN_W] : in_a[EXP_W+MAN_W];
    s1_big_exp_d  = s1_swap_d ? eexp_b : eexp_a;
    // Ordering guarantees big >= small, so this never wraps.
    s1_exp_diff_d  = s1_swap_d ? (eexp_b - eexp_a) : (eexp_a - eexp_b);
    s1_big_man_d   = s1_swap_d ? {hid_b, man_b} : {hid_a, man_a};
    s1_small_sig_d = s1_swap_d ? {hid_a, man_a} : {hid_b, man_b};
  end

  fp_align_shifter #(
    .W    (AL_W),
    .SH_W (EXP_W)
  ) u_shifter (
    .data_i  ({s1_small_sig_q, {GUARD_W{1'b0}}}),
    .shamt_i (s1_exp_diff_q),
    .data_o  (out_small_man_d)
  );

  assign out_adv  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || out_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q      <= 1'b0;
      s1_swap_q       <= 1'b0;
      s1_big_sign_q   <= 1'b0;
      s1_eff_sub_q    <= 1'b0;
      s1_special_q    <= 1'b0;
      s1_big_exp_q    <= '0;
      s1_exp_diff_q   <= '0;
      s1_big_man_q    <= '0;
      s1_small_sig_q  <= '0;
      out_valid_q     <= 1'b0;
      out_swap_q      <= 1'b0;
      out_big_sign_q  <= 1'b0;
      out_eff_sub_q   <= 1'b0;
      out_special_q   <= 1'b0;
      out_big_exp_q   <= '0;
      out_exp_diff_q  <= '0;
      out_big_man_q   <= '0;
      out_small_man_q <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_swap_q      <= s1_swap_d;
          s1_big_sign_q  <= s1_big_sign_d;
          s1_eff_sub_q   <= s1_eff_sub_d;
          s1_special_q   <= s1_special_d;
          s1_big_exp_q   <= s1_big_exp_d;
          s1_exp_diff_q  <= s1_exp_diff_d;
          s1_big_man_q   <= s1_big_man_d;
          s1_small_sig_q <= s1_small_sig_d;
        end
      end
      if (out_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_swap_q      <= s1_swap_q;
          out_big_sign_q  <= s1_big_sign_q;
          out_eff_sub_q   <= s1_eff_sub_q;
          out_special_q   <= s1_special_q;
          out_big_exp_q   <= s1_big_exp_q;
          out_exp_diff_q  <= s1_exp_diff_q;
          out_big_man_q   <= s1_big_man_q;
          out_small_man_q <= out_small_man_d;
        end
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_swap      = out_swap_q;
  assign out_big_sign  = out_big_sign_q;
  assign out_eff_sub   = out_eff_sub_q;
  assign out_special   = out_special_q;
  assign out_big_exp   = out_big_exp_q;
  assign out_exp_diff  = out_exp_diff_q;
  assign out_big_man   = out_big_man_q;
  assign out_small_man = out_small_man_q;

endmodule

// File: tb/tb_fp_align_pipe.sv
// tb/tb_fp_align_pipe.sv - self-checking bench for fp_align_pipe (FP32 defaults)
module tb_fp_align_pipe;

  typedef struct packed {
    logic        swap;
    logic        big_sign;
    logic        eff_sub;
    logic [7:0]  big_exp;
    logic [7:0]  exp_diff;
    logic [23:0] big_man;
    logic [26:0] small_man;
    logic        special;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic        out_swap;
  logic        out_big_sign;
  logic        out_eff_sub;
  logic [7:0]  out_big_exp;
  logic [7:0]  out_exp_diff;
  logic [23:0] out_big_man;
  logic [26:0] out_small_man;
  logic        out_special;

  int total = 0;
  int bad   = 0;

  fp_align_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_swap      (out_swap),
    .out_big_sign  (out_big_sign),
    .out_eff_sub   (out_eff_sub),
    .out_big_exp   (out_big_exp),
    .out_exp_diff  (out_exp_diff),
    .out_big_man   (out_big_man),
    .out_small_man (out_small_man),
    .out_special   (out_special)
  );

  always #5 clk = ~clk;

  function automatic res_t observed();
    return {out_swap, out_big_sign, out_eff_sub, out_big_exp, out_exp_diff,
            out_big_man, out_small_man, out_special};
  endfunction

  // Numeric view of an operand: ordering key, effective exponent, significand.
  function automatic void decode(input logic [31:0] x, output longint key,
                                 output longint eexp, output longint sig);
    longint e, m;
    e = longint'(x[30:23]);
    m = longint'(x[22:0]);
    if (e == 0) begin
`ifdef FP_ALIGN_SUBNORM_EN
      eexp = (m != 0) ? 1 : 0;
`else
      m    = 0;
      eexp = 0;
`endif
      sig = m;
    end else begin
      eexp = e;
      sig  = m + 64'd8388608;
    end
    key = e * 64'd8388608 + m;
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    longint ka, kb, xa, xb, sa, sb, xbig, xsml, sbig, ssml, d, ext, sm, p;
    logic   sw;
    decode(a, ka, xa, sa);
    decode(b, kb, xb, sb);
    sw   = (kb > ka);
    xbig = sw ? xb : xa;
    xsml = sw ? xa : xb;
    sbig = sw ? sb : sa;
    ssml = sw ? sa : sb;
    d    = xbig - xsml;
    ext  = ssml * 8;
    if (d >= 27) begin
      sm = (ext != 0) ? 1 : 0;
    end else begin
      p  = longint'(1) << d;
      sm = ext / p;
      if ((ext % p) != 0) sm = sm | 1;
    end
    r.swap      = sw;
    r.big_sign  = sw ? b[31] : a[31];
    r.eff_sub   = a[31] ^ b[31];
    r.big_exp   = 8'(xbig);
    r.exp_diff  = 8'(d);
    r.big_man   = 24'(sbig);
    r.small_man = 27'(sm);
    r.special   = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: x[30:23] = 8'h00;
      1: x[30:0]  = '0;
      2: x[30:23] = 8'(124 + $urandom_range(0, 6));
      3: x[30:23] = 8'hFF;
      default: ;
    endcase
    return x;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                          output res_t got, output bit ok);
    ok  = 1'b0;
    got = '0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = observed();
        ok  = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    total++;
    if (observed() !== res_t'('0)) begin
      bad++; $display("FAIL reset_out_data got=%h exp=0", observed());
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[8], vb[8];
    res_t        ve[8];
    res_t        got;
    bit          ok;
    va[0] = 32'h3F800000; vb[0] = 32'h40000000;
    ve[0] = '{1'b1, 1'b0, 1'b0, 8'h80, 8'd1,   24'h800000, 27'h2000000, 1'b0};
    va[1] = 32'h4B800000; vb[1] = 32'h3F800001;
    ve[1] = '{1'b0, 1'b0, 1'b0, 8'h97, 8'd24,  24'h800000, 27'h0000005, 1'b0};
    va[2] = 32'h7F000000; vb[2] = 32'h3F800000;
    ve[2] = '{1'b0, 1'b0, 1'b0, 8'hFE, 8'd127, 24'h800000, 27'h0000001, 1'b0};
    va[3] = 32'hC0400000; vb[3] = 32'hC0400000;
    ve[3] = '{1'b0, 1'b1, 1'b0, 8'h80, 8'd0,   24'hC00000, 27'h6000000, 1'b0};
    va[4] = 32'h00400000; vb[4] = 32'h00000000;
`ifdef FP_ALIGN_SUBNORM_EN
    ve[4] = '{1'b0, 1'b0, 1'b0, 8'h01, 8'd1,   24'h400000, 27'h0000000, 1'b0};
`else
    ve[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0,   24'h000000, 27'h0000000, 1'b0};
`endif
    va[5] = 32'h7F800000; vb[5] = 32'h3F800000;
    ve[5] = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'd128, 24'h800000, 27'h0000001, 1'b1};
    va[6] = 32'hBF800000; vb[6] = 32'h40000000;
    ve[6] = '{1'b1, 1'b0, 1'b1, 8'h80, 8'd1,   24'h800000, 27'h2000000, 1'b0};
    va[7] = 32'h3FC00000; vb[7] = 32'hBFC00001;
    ve[7] = '{1'b1, 1'b1, 1'b1, 8'h7F, 8'd0,   24'hC00001, 27'h6000000, 1'b0};
    for (int i = 0; i < 8; i++) begin
      run_pair(va[i], vb[i], got, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL directed_%0d_timeout got=no_output exp=out_valid", i);
      end else if (got !== ve[i]) begin
        bad++; $display("FAIL directed_%0d got=%h exp=%h", i, got, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa[4], pb[4];
    res_t        exp_q[$];
    res_t        snap, e;
    bit          have_snap;
    int          acc, got_n, last_cyc;
    have_snap = 1'b0; acc = 0; got_n = 0; last_cyc = -1; snap = '0;
    for (int i = 0; i < 4; i++) begin
      pa[i] = rand_op();
      pb[i] = rand_op();
    end
    for (int cyc = 0; cyc < 30 && got_n < 4; cyc++) begin
      @(posedge clk); #1;
      in_valid = (acc < 4);
      if (acc < 4) begin in_a = pa[acc]; in_b = pb[acc]; end
      out_ready = (cyc >= 6);
      @(negedge clk);
      if (cyc < 6) begin
        total++;
        if (in_ready !== (acc < 2)) begin
          bad++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, acc < 2);
        end
        if (out_valid && have_snap) begin
          total++;
          if (observed() !== snap) begin
            bad++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, observed(), snap);
          end
        end else if (out_valid) begin
          snap = observed(); have_snap = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(pa[acc], pb[acc]));
        acc++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra got=%h exp=none", observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin
            bad++; $display("FAIL b2b_data_%0d got=%h exp=%h", got_n, observed(), e);
          end
        end
        if (last_cyc >= 0) begin
          total++;
          if (cyc != last_cyc + 1) begin
            bad++; $display("FAIL b2b_gap got=%0d exp=%0d", cyc, last_cyc + 1);
          end
        end
        last_cyc = cyc;
        got_n++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (got_n != 4) begin
      bad++; $display("FAIL b2b_count got=%0d exp=4", got_n);
    end
  endtask

  task automatic test_random();
    res_t        exp_q[$];
    res_t        e;
    logic [31:0] a, b;
    int          seen;
    seen = 0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 400) begin
        if (!in_valid) begin
          if ($urandom_range(0, 9) < 7) begin
            a = rand_op();
            b = rand_op();
            if ($urandom_range(0, 3) == 0) b[30:23] = a[30:23];
            if ($urandom_range(0, 7) == 0) b = a;
            in_a = a; in_b = b; in_valid = 1'b1;
          end
        end
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra got=%h exp=none", observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin
            bad++; $display("FAIL rand_data_%0d got=%h exp=%h", seen, observed(), e);
          end
        end
        seen++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b));
        // Next cycle may present a fresh pair; a held pair stays asserted.
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        if (out_valid && out_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL rand_extra got=%h exp=none", observed());
          end else begin
            e = exp_q.pop_front();
            if (observed() !== e) begin
              bad++; $display("FAIL rand_data_%0d got=%h exp=%h", seen, observed(), e);
            end
          end
          seen++;
        end
      end
    end
    out_ready = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL rand_lost got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); out_ready = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL midrst_stale_%0d got=%b exp=0", i, out_valid);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
